// File: rtl/ascii_dec_pkg.sv
// Shared character constants, parser states and byte classifier for the ASCII decimal parser.
// ASCII_DEC_SIGN_EN makes '-' a distinct character class so signed numbers can be parsed.
package ascii_dec_pkg;

  localparam logic [7:0] ASCII_ZERO  = 8'h30;
  localparam logic [7:0] ASCII_NINE  = 8'h39;
  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_LF    = 8'h0A;
  localparam logic [7:0] ASCII_MINUS = 8'h2D;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCUM   = 2'd1,
    DISCARD = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    CLS_DIGIT = 2'd0,
    CLS_TERM  = 2'd1,
    CLS_MINUS = 2'd2,
    CLS_OTHER = 2'd3
  } char_cls_e;

  function automatic char_cls_e classify(input logic [7:0] b);
    char_cls_e cls;
    if ((b >= ASCII_ZERO) && (b <= ASCII_NINE)) begin
      cls = CLS_DIGIT;
    end else if ((b == ASCII_CR) || (b == ASCII_LF)) begin
      cls = CLS_TERM;
`ifdef ASCII_DEC_SIGN_EN
    end else if (b == ASCII_MINUS) begin
      cls = CLS_MINUS;
`endif
    end else begin
      cls = CLS_OTHER;
    end
    return cls;
  endfunction

endpackage

// File: rtl/ascii_dec_mac.sv
// Combinational acc*10+digit with an overflow flag against the active magnitude limit.
// With ASCII_DEC_SIGN_EN the limit depends on the sign of the number being parsed.
module ascii_dec_mac #(
  parameter int VALUE_W = 16
) (
  input  logic [VALUE_W-1:0] acc,
  input  logic [3:0]         digit,
`ifdef ASCII_DEC_SIGN_EN
  input  logic               neg,
`endif
  output logic [VALUE_W-1:0] next_val,
  output logic               ovf
);

  localparam int WIDE_W = VALUE_W + 4;

  logic [WIDE_W-1:0] acc_wide_s;
  logic [WIDE_W-1:0] sum_s;
  logic [WIDE_W-1:0] limit_s;

  // Shift-add multiply by ten; the four extra bits hold 10*(2^VALUE_W-1)+9 without wrap.
  always_comb begin
    acc_wide_s = WIDE_W'(acc);
    sum_s      = (acc_wide_s << 3) + (acc_wide_s << 1) + WIDE_W'(digit);
`ifdef ASCII_DEC_SIGN_EN
    if (neg) begin
      limit_s = WIDE_W'(1) << (VALUE_W - 1);
    end else begin
      limit_s = (WIDE_W'(1) << (VALUE_W - 1)) - WIDE_W'(1);
    end
`else
    limit_s = (WIDE_W'(1) << VALUE_W) - WIDE_W'(1);
`endif
    ovf      = (sum_s > limit_s);
    next_val = sum_s[VALUE_W-1:0];
  end

endmodule

// File: rtl/ascii_dec_parser.sv
// Accumulates ASCII decimal digits from a UART RX byte stream into a binary value, strobed on CR/LF.
// Build with ASCII_DEC_SIGN_EN to accept a leading '-' and emit two's complement results.
module ascii_dec_parser
  import ascii_dec_pkg::*;
#(
  parameter int VALUE_W    = 16,
  parameter int MAX_DIGITS = 5
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [7:0]                        rx_data,
  input  logic                              rx_valid,
  output logic [VALUE_W-1:0]                value_out,
  output logic                              value_valid,
  output logic                              err,
  output logic                              busy,
  output logic [$clog2(MAX_DIGITS+1)-1:0]   digit_cnt
);

  localparam int                CNT_W   = $clog2(MAX_DIGITS + 1);
  localparam logic [CNT_W-1:0]  MAX_CNT = CNT_W'(MAX_DIGITS);

  state_e              state_r;
  logic [VALUE_W-1:0]  acc_r;
  logic [VALUE_W-1:0]  value_out_r;
  logic                value_valid_r;
  logic                err_r;
  logic                busy_r;
  logic [CNT_W-1:0]    digit_cnt_r;
  char_cls_e           cls_s;
  logic [VALUE_W-1:0]  next_s;
  logic                ovf_s;
  logic [VALUE_W-1:0]  result_s;
`ifdef ASCII_DEC_SIGN_EN
  logic                neg_r;
`endif

  // Byte classification and the signed/unsigned view of the finished magnitude.
  always_comb begin
    cls_s = classify(rx_data);
`ifdef ASCII_DEC_SIGN_EN
    if (neg_r) begin
      result_s = (~acc_r) + VALUE_W'(1);
    end else begin
      result_s = acc_r;
    end
`else
    result_s = acc_r;
`endif
  end

  // acc_r is zero whenever the FSM is in IDLE, so the first digit goes through the same MAC path.
  ascii_dec_mac #(
    .VALUE_W (VALUE_W)
  ) u_mac (
    .acc      (acc_r),
    .digit    (rx_data[3:0]),
`ifdef ASCII_DEC_SIGN_EN
    .neg      (neg_r),
`endif
    .next_val (next_s),
    .ovf      (ovf_s)
  );

  // Parser FSM with registered result, strobes, busy and digit count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= IDLE;
      acc_r         <= '0;
      value_out_r   <= '0;
      value_valid_r <= 1'b0;
      err_r         <= 1'b0;
      busy_r        <= 1'b0;
      digit_cnt_r   <= '0;
`ifdef ASCII_DEC_SIGN_EN
      neg_r         <= 1'b0;
`endif
    end else begin
      value_valid_r <= 1'b0;
      err_r         <= 1'b0;
      if (rx_valid) begin
        case (state_r)
          IDLE: begin
            case (cls_s)
              CLS_DIGIT: begin
                acc_r       <= next_s;
                digit_cnt_r <= CNT_W'(1);
                state_r     <= ACCUM;
                busy_r      <= 1'b1;
              end
              CLS_TERM: begin
                state_r <= IDLE;
              end
`ifdef ASCII_DEC_SIGN_EN
              CLS_MINUS: begin
                neg_r       <= 1'b1;
                digit_cnt_r <= '0;
                state_r     <= ACCUM;
                busy_r      <= 1'b1;
              end
`endif
              default: begin
                state_r <= DISCARD;
                busy_r  <= 1'b1;
              end
            endcase
          end
          ACCUM: begin
            case (cls_s)
              CLS_DIGIT: begin
                if (ovf_s || (digit_cnt_r == MAX_CNT)) begin
                  state_r <= DISCARD;
                end else begin
                  acc_r       <= next_s;
                  digit_cnt_r <= digit_cnt_r + CNT_W'(1);
                end
              end
              CLS_TERM: begin
`ifdef ASCII_DEC_SIGN_EN
                // A bare '-' with no digits is malformed.
                if (neg_r && (digit_cnt_r == '0)) begin
                  err_r <= 1'b1;
                end else begin
                  value_out_r   <= result_s;
                  value_valid_r <= 1'b1;
                end
                neg_r <= 1'b0;
`else
                value_out_r   <= result_s;
                value_valid_r <= 1'b1;
`endif
                acc_r       <= '0;
                digit_cnt_r <= '0;
                state_r     <= IDLE;
                busy_r      <= 1'b0;
              end
              default: begin
                state_r <= DISCARD;
              end
            endcase
          end
          DISCARD: begin
            if (cls_s == CLS_TERM) begin
              err_r       <= 1'b1;
              acc_r       <= '0;
              digit_cnt_r <= '0;
              state_r     <= IDLE;
              busy_r      <= 1'b0;
`ifdef ASCII_DEC_SIGN_EN
              neg_r       <= 1'b0;
`endif
            end else begin
              state_r <= DISCARD;
            end
          end
          default: begin
            acc_r       <= '0;
            digit_cnt_r <= '0;
            state_r     <= IDLE;
            busy_r      <= 1'b0;
          end
        endcase
      end
    end
  end

  assign value_out   = value_out_r;
  assign value_valid = value_valid_r;
  assign err         = err_r;
  assign busy        = busy_r;
  assign digit_cnt   = digit_cnt_r;

endmodule

// File: tb/tb_ascii_dec_parser.sv
// Directed self-checking bench for ascii_dec_parser (VALUE_W=16, MAX_DIGITS=5).
// Signed vectors are exercised when ASCII_DEC_SIGN_EN is defined.
module tb_ascii_dec_parser;

  localparam int VALUE_W    = 16;
  localparam int MAX_DIGITS = 5;
  localparam int CNT_W      = $clog2(MAX_DIGITS + 1);

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic [7:0]         rx_data = 8'h00;
  logic               rx_valid = 1'b0;
  logic [VALUE_W-1:0] value_out;
  logic               value_valid;
  logic               err;
  logic               busy;
  logic [CNT_W-1:0]   digit_cnt;

  int n_checks   = 0;
  int n_fail     = 0;
  int valid_seen = 0;
  int err_seen   = 0;
  int both_seen  = 0;

  ascii_dec_parser #(
    .VALUE_W    (VALUE_W),
    .MAX_DIGITS (MAX_DIGITS)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .value_out   (value_out),
    .value_valid (value_valid),
    .err         (err),
    .busy        (busy),
    .digit_cnt   (digit_cnt)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (value_valid) valid_seen++;
    if (err) err_seen++;
    if (value_valid && err) both_seen++;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Presents one byte for exactly one clock; returns at the negedge after it was consumed.
  task automatic send(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_str(input string s, input int gap);
    for (int i = 0; i < s.len(); i++) begin
      send(s[i]);
      if (gap > 1) idle(gap - 1);
    end
  endtask

  task automatic clear_counts();
    valid_seen = 0;
    err_seen   = 0;
  endtask

  initial begin
    idle(3);
    check_eq("reset_value_out", 32'(value_out), 32'd0);
    check_eq("reset_valid", 32'(value_valid), 32'd0);
    check_eq("reset_err", 32'(err), 32'd0);
    check_eq("reset_busy", 32'(busy), 32'd0);
    check_eq("reset_digit_cnt", 32'(digit_cnt), 32'd0);
    rst_n = 1'b1;
    idle(2);

    // "123\r", one byte every 4 clocks
    clear_counts();
    send(8'h31);
    check_eq("123_busy_after_1", 32'(busy), 32'd1);
    check_eq("123_cnt_after_1", 32'(digit_cnt), 32'd1);
    idle(3);
    send_str("23", 4);
    check_eq("123_cnt_after_3", 32'(digit_cnt), 32'd3);
    send(8'h0D);
    check_eq("123_valid_lat1", 32'(value_valid), 32'd1);
    check_eq("123_value", 32'(value_out), 32'd123);
    check_eq("123_err_low", 32'(err), 32'd0);
    idle(3);
    check_eq("123_valid_pulse_count", 32'(valid_seen), 32'd1);
    check_eq("123_err_count", 32'(err_seen), 32'd0);
    check_eq("123_busy_clear", 32'(busy), 32'd0);
    check_eq("123_cnt_clear", 32'(digit_cnt), 32'd0);

    // "65535\r\n" back to back
    clear_counts();
    send_str("65535", 1);
    send(8'h0D);
    send(8'h0A);
    idle(3);
    check_eq("65535_valid_count", 32'(valid_seen), 32'd1);
    check_eq("65535_value", 32'(value_out), 32'h0000FFFF);
    check_eq("65535_err_count", 32'(err_seen), 32'd0);

    // "65536\r" overflows
    clear_counts();
    send_str("65536", 1);
    check_eq("65536_busy_discard", 32'(busy), 32'd1);
    send(8'h0D);
    check_eq("65536_err_lat1", 32'(err), 32'd1);
    idle(3);
    check_eq("65536_valid_count", 32'(valid_seen), 32'd0);
    check_eq("65536_err_count", 32'(err_seen), 32'd1);
    check_eq("65536_value_held", 32'(value_out), 32'h0000FFFF);

    // six digits exceed MAX_DIGITS even though 12345 fits
    clear_counts();
    send_str("12345", 1);
    check_eq("maxdig_cnt5", 32'(digit_cnt), 32'd5);
    send_str("6", 1);
    check_eq("maxdig_busy", 32'(busy), 32'd1);
    send(8'h0D);
    idle(3);
    check_eq("maxdig_err_count", 32'(err_seen), 32'd1);
    check_eq("maxdig_valid_count", 32'(valid_seen), 32'd0);
    check_eq("maxdig_value_held", 32'(value_out), 32'h0000FFFF);

    // "12a4\r7\n"
    clear_counts();
    send_str("12a4", 1);
    send(8'h0D);
    check_eq("12a4_err_pulse", 32'(err), 32'd1);
    check_eq("12a4_no_valid", 32'(value_valid), 32'd0);
    send_str("7", 1);
    send(8'h0A);
    check_eq("7_valid", 32'(value_valid), 32'd1);
    check_eq("7_value", 32'(value_out), 32'd7);
    idle(3);
    check_eq("12a4_err_count", 32'(err_seen), 32'd1);
    check_eq("12a4_valid_count", 32'(valid_seen), 32'd1);

    // leading zeros and blank terminators
    clear_counts();
    send_str("0042", 1);
    send(8'h0D);
    send(8'h0A);
    send(8'h0D);
    idle(3);
    check_eq("0042_value", 32'(value_out), 32'd42);
    check_eq("0042_valid_count", 32'(valid_seen), 32'd1);
    check_eq("blank_err_count", 32'(err_seen), 32'd0);
    check_eq("blank_busy", 32'(busy), 32'd0);

    // reset mid-number
    clear_counts();
    send_str("98", 1);
    rst_n = 1'b0;
    #1;
    check_eq("midrst_value_out", 32'(value_out), 32'd0);
    check_eq("midrst_busy", 32'(busy), 32'd0);
    check_eq("midrst_digit_cnt", 32'(digit_cnt), 32'd0);
    idle(3);
    check_eq("midrst_valid", 32'(value_valid), 32'd0);
    check_eq("midrst_err", 32'(err), 32'd0);
    rst_n = 1'b1;
    idle(1);
    send_str("5", 1);
    send(8'h0D);
    idle(3);
    check_eq("after_rst_value", 32'(value_out), 32'd5);
    check_eq("after_rst_valid_count", 32'(valid_seen), 32'd1);
    check_eq("after_rst_err_count", 32'(err_seen), 32'd0);

`ifdef ASCII_DEC_SIGN_EN
    clear_counts();
    send_str("-32768", 1);
    send(8'h0D);
    check_eq("neg32768_valid", 32'(value_valid), 32'd1);
    check_eq("neg32768_value", 32'(value_out), 32'h00008000);
    send_str("-5", 1);
    send(8'h0D);
    check_eq("neg5_value", 32'(value_out), 32'h0000FFFB);
    send_str("32767", 1);
    send(8'h0D);
    check_eq("pos32767_value", 32'(value_out), 32'h00007FFF);
    idle(3);
    check_eq("sign_valid_count", 32'(valid_seen), 32'd3);
    clear_counts();
    send_str("-32769", 1);
    send(8'h0D);
    send_str("32768", 1);
    send(8'h0D);
    send_str("-", 1);
    send(8'h0D);
    check_eq("bare_minus_err", 32'(err), 32'd1);
    send_str("5-", 1);
    send(8'h0D);
    idle(3);
    check_eq("sign_err_count", 32'(err_seen), 32'd4);
    check_eq("sign_err_valid_count", 32'(valid_seen), 32'd0);
    check_eq("sign_err_value_held", 32'(value_out), 32'h00007FFF);
`else
    clear_counts();
    send_str("-5", 1);
    send(8'h0D);
    idle(3);
    check_eq("minus_other_err_count", 32'(err_seen), 32'd1);
    check_eq("minus_other_valid_count", 32'(valid_seen), 32'd0);
    check_eq("minus_other_value_held", 32'(value_out), 32'd5);
`endif

    check_eq("valid_err_exclusive", 32'(both_seen), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
